unison_array_sequencer: RTL
===========================

# unison_array_sequencer

Parametrised controller for an array of `digital_unison` channels. It replaces per-channel logic-analyser bit driving with an on-chip sequencer. The block generates a reset pulse and gated `clk_master` clocks for `NUM_CH` channels. On each master period it scans the 2-bit I/Q readouts of the enabled channels into a timestamped FIFO that firmware drains over a valid/ready port. It sits between the channel array and the Wishbone/LA glue in the user project wrapper.

## Interface
- `NUM_CH`, default 6: number of unison channels (1..16); `CH_W = max(1, clog2(NUM_CH))`.
- `DIV_W`, default 16: width of the half-period divider.
- `FIFO_DEPTH`, default 8: sample FIFO entries (power of two, ≥2).
- `RST_CYC`, default 4: cycles `rstb` is held low in `RESET`.
- `TS_W`, default 8: sample-counter timestamp width.
- `wb_clk_i`  in  1: sole clock.
- `wb_rst_i`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; begins a run from `IDLE`.
- `stop`  in  1: one-cycle pulse; ends a run.
- `cfg_div`  in  DIV_W: `clk_master` half-period in `wb_clk_i` cycles; 0 is treated as 1.
- `cfg_ch_en`  in  NUM_CH: per-channel enable; sampled once at `start`, held for the run.
- `read_out_I`  in  2*NUM_CH: channel k occupies bits [2k+1:2k].
- `read_out_Q`  in  2*NUM_CH: same layout as `read_out_I`.
- `clk_master`  out  NUM_CH: gated master clocks.
- `rstb`  out  1: active-low channel reset.
- `busy`  out  1: high in `RESET` or `RUN`.
- `rd_valid`  out  1: FIFO non-empty.
- `rd_data`  out  TS_W+CH_W+4: {timestamp, ch, I[1:0], Q[1:0]}, MSB first.
- `rd_ready`  in  1: pop strobe; a pop happens when `rd_valid & rd_ready`.
- `ovf`  out  1: sticky; a FIFO push was dropped. Cleared by `start` or reset.
- `overrun`  out  1: sticky; a sample tick arrived mid-scan. Cleared by `start` or reset.

## Operation
- **States: `IDLE` → `RESET` → `RUN` → `IDLE`.**
  - `IDLE`: `rstb=0`, `clk_master=0`.
  - On `start`: latch `cfg_ch_en` into `en_q`, clear `ovf`, `overrun` and the timestamp, load the reset counter, go to `RESET`.
  - `RESET`: `rstb=0` for exactly `RST_CYC` cycles, then go to `RUN`.
  - `RUN`: `rstb=1`. `stop` returns to `IDLE` next cycle; phase, divider and scan are cleared, FIFO contents are kept.
  - `start` while not in `IDLE` is ignored.
  - `stop` in `RESET` returns to `IDLE`.
- **Divider (`RUN` only):**
  - `div_cnt` counts 0..max(cfg_div,1)-1.
  - At terminal count it toggles `phase` and wraps to 0.
  - `clk_master = en_q & {NUM_CH{phase}}`, registered.
- **Sample tick:**
  - A tick is the cycle `phase` toggles 1→0.
  - A tick starts a scan at channel 0 and then increments the timestamp, modulo 2^TS_W.
- **Scan:**
  - One channel index per cycle, 0..NUM_CH-1.
  - For each enabled channel, push {timestamp before increment, k, I_k, Q_k}. I/Q are sampled in the push cycle.
  - Disabled channels consume a cycle but push nothing.
  - A scan takes NUM_CH cycles.
  - A tick during an active scan sets `overrun`, aborts the old scan and restarts at channel 0.
- **FIFO:**
  - Push when full drops the word and sets `ovf`.
  - Push and pop in the same cycle when full: pop first, push accepted, `ovf` not set.
  - Pop when empty: no effect.
- **Reset (`wb_rst_i`), any time:**
  - `IDLE`; FIFO emptied.
  - All outputs 0: `rstb=0`, `busy=0`, `rd_valid=0`, `rd_data=0`, `ovf=0`, `overrun=0`, `clk_master=0`.

## Timing
- `start` at cycle 0 → `busy=1` and `rstb=0` at cycle 1 → `rstb=1` at cycle 1+RST_CYC.
- First `phase` rise is D cycles after `RUN` entry, where D = max(cfg_div,1). `clk_master` period is 2D.
- First push is 1 cycle after a tick. The last push of a scan is NUM_CH cycles after the tick.
- Overrun-free runs require 2D ≥ NUM_CH.
- `rd_valid` rises 1 cycle after a push into an empty FIFO. `rd_data` is valid whenever `rd_valid=1` and is stable until popped. No bypass path.
- `busy` falls 1 cycle after `stop`.

## Test plan
- **Reset/start:** reset, then `start` with NUM_CH=6, RST_CYC=4, cfg_div=8, en=6'b111111 → `rstb` low cycles 1–4, high at cycle 5; `clk_master` all bits toggle every 8 cycles.
- **Scan content:** en=6'b100101, I_k=k[1:0], Q_k=~k[1:0], `rd_ready=1` → per tick exactly 3 words, ch 0, 2, 5, same timestamp; timestamp increments 0, 1, 2…
- **FIFO overflow:** FIFO_DEPTH=8, en all, `rd_ready=0`, two ticks → 8 words stored, `ovf=1` after the 9th push attempt; drain yields ch 0..5 (ts 0), then ch 0..1 (ts 1).
- **Full push+pop:** full FIFO, `rd_ready=1` held through a scan → no `ovf`, each word popped in order.
- **Overrun:** cfg_div=2, NUM_CH=6 → `overrun=1` at the 2nd tick; scan restarts at ch 0.
- **Stop/reset mid-run:** `stop` mid-scan → `clk_master=0` and `busy=0` next cycle, buffered words still readable. `wb_rst_i` mid-run → all outputs 0 next cycle, `rd_valid=0`.

Source files
------------

// File: rtl/unison_array_sequencer.sv
// Sequencer for an array of digital_unison channels: drives the channel reset and
// gated master clocks, and scans each channel's I/Q readout into a timestamped FIFO.
module unison_array_sequencer #(
  parameter int NUM_CH     = 6,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYC    = 4,
  parameter int TS_W       = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W    = TS_W + CH_W + 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                stop,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [NUM_CH-1:0]   cfg_ch_en,
  input  logic [2*NUM_CH-1:0] read_out_I,
  input  logic [2*NUM_CH-1:0] read_out_Q,
  output logic [NUM_CH-1:0]   clk_master,
  output logic                rstb,
  output logic                busy,
  output logic                rd_valid,
  output logic [WORD_W-1:0]   rd_data,
  input  logic                rd_ready,
  output logic                ovf,
  output logic                overrun
);

  localparam int RC_W  = $clog2(RST_CYC + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN} state_t;

  state_t              state_reg, state_next;
  logic                start_ok;
  logic [RC_W-1:0]     rst_cnt_reg;
  logic [NUM_CH-1:0]   en_q_reg;
  logic [NUM_CH-1:0]   clk_master_reg;
  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next, div_max;
  logic                phase_reg, phase_next;
  logic                run, run_next, div_term, tick;
  logic                scan_active_reg, scan_active_next;
  logic [CH_W-1:0]     scan_idx_reg, scan_idx_next;
  logic                scan_last, scan_push;
  logic [TS_W-1:0]     ts_reg, scan_ts_reg;
  logic                ovf_reg, overrun_reg;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                fifo_full, pop, push_ok, push_drop;
  logic [WORD_W-1:0]   push_word;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RESET;
          start_ok   = 1'b1;
        end
      end
      S_RESET: begin
        if (stop)                           state_next = S_IDLE;
        else if (rst_cnt_reg == RC_W'(1))   state_next = S_RUN;
      end
      S_RUN: begin
        if (stop) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Divider and scan only advance while staying in RUN; leaving RUN clears them.
  always_comb begin
    run      = (state_reg == S_RUN);
    run_next = (state_next == S_RUN);
    div_max  = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
    div_term = (div_cnt_reg >= div_max);
    tick     = run & div_term & phase_reg;

    div_cnt_next = '0;
    phase_next   = 1'b0;
    if (run && run_next) begin
      div_cnt_next = div_term ? '0 : div_cnt_reg + DIV_W'(1);
      phase_next   = div_term ? ~phase_reg : phase_reg;
    end

    scan_last        = (scan_idx_reg == CH_W'(NUM_CH - 1));
    scan_push        = run & scan_active_reg & en_q_reg[scan_idx_reg];
    scan_active_next = 1'b0;
    scan_idx_next    = '0;
    if (run_next) begin
      if (tick) begin
        scan_active_next = 1'b1;
      end else if (scan_active_reg && !scan_last) begin
        scan_active_next = 1'b1;
        scan_idx_next    = scan_idx_reg + CH_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rst_cnt_reg     <= '0;
      en_q_reg        <= '0;
      div_cnt_reg     <= '0;
      phase_reg       <= 1'b0;
      scan_active_reg <= 1'b0;
      scan_idx_reg    <= '0;
      ts_reg          <= '0;
      scan_ts_reg     <= '0;
      ovf_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      phase_reg       <= phase_next;
      scan_active_reg <= scan_active_next;
      scan_idx_reg    <= scan_idx_next;
      if (start_ok) begin
        rst_cnt_reg <= RC_W'(RST_CYC);
        en_q_reg    <= cfg_ch_en;
        ts_reg      <= '0;
        ovf_reg     <= 1'b0;
        overrun_reg <= 1'b0;
      end else begin
        if (state_reg == S_RESET) rst_cnt_reg <= rst_cnt_reg - RC_W'(1);
        if (tick) begin
          scan_ts_reg <= ts_reg;
          ts_reg      <= ts_reg + TS_W'(1);
        end
        // The final channel is still sampled on a coinciding tick, so it is not an overrun.
        if (tick && scan_active_reg && !scan_last) overrun_reg <= 1'b1;
        if (push_drop) ovf_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_clk_master
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) clk_master_reg[gi] <= 1'b0;
        else          clk_master_reg[gi] <= en_q_reg[gi] & phase_next;
      end
    end
  endgenerate

  // Sample FIFO; a pop frees the slot for a same-cycle push when full.
  assign push_word = {scan_ts_reg, scan_idx_reg,
                      read_out_I[{scan_idx_reg, 1'b0} +: 2],
                      read_out_Q[{scan_idx_reg, 1'b0} +: 2]};
  assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop       = rd_ready & (count_reg != '0);
  assign push_ok   = scan_push & (~fifo_full | pop);
  assign push_drop = scan_push & ~push_ok;

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_valid   = (count_reg != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr_reg] : '0;
  assign clk_master = clk_master_reg;
  assign rstb       = (state_reg == S_RUN);
  assign busy       = (state_reg != S_IDLE);
  assign ovf        = ovf_reg;
  assign overrun    = overrun_reg;

endmodule
